// File: rtl/mvu_apb_master.sv
// mvu_apb_master: valid/ready command stream to APB initiator with wait-state timeout
module mvu_apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [2:0]              pprot,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    typedef enum logic [1:0] {idle, setup, access, resp} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    assign cmd_ready = state == idle;
    assign pprot = 3'b000;
    // One access at a time: latch command, run APB setup/access, hold response until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= idle;
            cnt         <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                idle: if (cmd_valid) begin
                    pwrite <= cmd_write;
                    paddr  <= cmd_addr;
                    pwdata <= cmd_wdata;
                    pstrb  <= cmd_write ? cmd_strb : '0;
                    cnt    <= '0;
                    psel   <= 1'b1;
                    state  <= setup;
                end
                setup: begin
                    penable <= 1'b1;
                    state   <= access;
                end
                access: if (pready) begin
                    rsp_rdata   <= pwrite ? '0 : prdata;
                    rsp_err     <= pslverr;
                    rsp_timeout <= 1'b0;
                    rsp_valid   <= 1'b1;
                    psel        <= 1'b0;
                    penable     <= 1'b0;
                    state       <= resp;
                end else if (TIMEOUT_CYCLES != 0 && cnt == LAST) begin
                    rsp_rdata   <= '0;
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b1;
                    rsp_valid   <= 1'b1;
                    psel        <= 1'b0;
                    penable     <= 1'b0;
                    state       <= resp;
                end else if (~&cnt) begin
                    cnt <= cnt + 1'b1;
                end
                resp: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= idle;
                end
                default: state <= idle;
            endcase
        end
    end
endmodule

// File: tb/tb_mvu_apb_master.sv
// tb_mvu_apb_master: directed vector table plus backpressure and reset corner cases
module tb_mvu_apb_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata, paddr, pwdata, prdata = '0;
    logic [2:0]  pprot;
    logic        psel, penable, pwrite, pready = 1'b0, pslverr = 1'b0;
    logic [3:0]  pstrb;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mvu_apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] rdata_in;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int idx);
        int cyc;
        int aw;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_strb = v.strb;
        chk($sformatf("v%0d cmd_ready", idx), cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 1;
        chk($sformatf("v%0d setup psel", idx), psel, 1);
        chk($sformatf("v%0d setup penable", idx), penable, 0);
        chk($sformatf("v%0d paddr", idx), paddr, v.addr);
        chk($sformatf("v%0d pwrite", idx), pwrite, v.wr);
        chk($sformatf("v%0d pwdata", idx), pwdata, v.wdata);
        chk($sformatf("v%0d pstrb", idx), pstrb, v.wr ? v.strb : 4'h0);
        aw = 0;
        while (!rsp_valid && cyc < 20) begin
            if (cyc == 2) chk($sformatf("v%0d access penable", idx), penable, 1);
            if (psel && penable) begin
                if (paddr !== v.addr || pwdata !== v.wdata || pwrite !== v.wr)
                    chk($sformatf("v%0d access stable", idx), paddr, v.addr);
                pready = (aw == v.waits);
                aw++;
            end else pready = 1'b0;
            prdata  = pready ? v.rdata_in : 32'hBADBAD00;
            pslverr = pready ? v.slverr : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        pready = 1'b0; pslverr = 1'b0;
        if (!rsp_valid) begin
            total++; bad++;
            $display("FAIL v%0d no response within 20 cycles", idx);
        end
        chk($sformatf("v%0d latency", idx), cyc, v.exp_lat);
        chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d rsp_err", idx), rsp_err, v.exp_err);
        chk($sformatf("v%0d rsp_timeout", idx), rsp_timeout, v.exp_to);
        chk($sformatf("v%0d resp psel", idx), {psel, penable, cmd_ready}, 3'b000);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk($sformatf("v%0d rsp_valid drop", idx), rsp_valid, 0);
        chk($sformatf("v%0d back idle", idx), cmd_ready, 1);
    endtask

    initial begin
        int c;
        logic ok;
        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 3};
        vecs[1] = '{1'b0, 32'h24, 32'h0, 4'hF, 3, 32'h12345678, 1'b0, 32'h12345678, 1'b0, 1'b0, 6};
        vecs[2] = '{1'b1, 32'h30, 32'h0BADF00D, 4'h3, 1, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 4};
        vecs[3] = '{1'b0, 32'h34, 32'h0, 4'h0, 0, 32'hCAFE0001, 1'b1, 32'hCAFE0001, 1'b1, 1'b0, 3};
        vecs[4] = '{1'b0, 32'h38, 32'h0, 4'h0, 99, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 6};
        vecs[5] = '{1'b1, 32'h3C, 32'h11112222, 4'hC, 99, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 6};
        vecs[6] = '{1'b1, 32'h44, 32'h5A5A5A5A, 4'h1, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 3};
        vecs[7] = '{1'b0, 32'h48, 32'h0, 4'h0, 2, 32'hA5A5F00F, 1'b0, 32'hA5A5F00F, 1'b0, 1'b0, 5};

        repeat (3) @(posedge clk);
        #1;
        chk("reset psel/penable/rsp_valid", {psel, penable, rsp_valid, pwrite}, 4'b0000);
        chk("reset paddr", paddr, 0);
        chk("reset pwdata", pwdata, 0);
        chk("reset rsp", {rsp_rdata[27:0], pstrb, rsp_err, rsp_timeout}, 0);
        rst = 1'b0;
        #1;
        chk("reset cmd_ready", cmd_ready, 1);
        chk("pprot", pprot, 0);

        for (int i = 0; i < 8; i++) run(vecs[i], i);

        // backpressure with cmd_valid held high across transfers
        pready = 1'b1; prdata = 32'h77; pslverr = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50; cmd_strb = 4'hF;
        c = 0;
        while (!rsp_valid && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        chk("bp first response", rsp_valid, 1);
        chk("bp rdata", rsp_rdata, 32'h77);
        cmd_addr = 32'h60; cmd_write = 1'b1; cmd_wdata = 32'h1234; prdata = 32'h99;
        ok = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h77 || cmd_ready !== 1'b0 || psel !== 1'b0) ok = 1'b0;
        end
        chk("bp hold stable", ok, 1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp after handshake", {cmd_ready, rsp_valid, psel}, 3'b100);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("bp second accepted psel", psel, 1);
        chk("bp second paddr", paddr, 32'h60);
        chk("bp second pwrite/pstrb", {pwrite, pstrb}, 5'b11111);
        c = 0;
        while (!rsp_valid && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        chk("bp second response", {rsp_valid, rsp_err, rsp_timeout}, 3'b100);
        chk("bp second rdata", rsp_rdata, 0);
        @(posedge clk); #1;
        rsp_ready = 1'b0; pready = 1'b0;
        chk("bp second done", rsp_valid, 0);

        // reset asserted mid-ACCESS
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h80;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst access entered", {psel, penable}, 2'b11);
        #2 rst = 1'b1;
        #1;
        chk("rst async drop", {psel, penable, rsp_valid}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0; pready = 1'b1; prdata = 32'hEE;
        ok = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || psel !== 1'b0 || cmd_ready !== 1'b1) ok = 1'b0;
        end
        pready = 1'b0;
        chk("rst no response after", ok, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mvu_apb_master.md
# mvu_apb_master

APB initiator that issues CSR accesses toward the MVU's APB slave port (`mvutop_wrapper`). A simple valid/ready command stream supplies the accesses, and the block returns results on a valid/ready response stream. It replaces the simulation-only APB driver with synthesizable RTL, so an on-chip controller or sequencer can program MVU jobs. One access is outstanding at a time. Each access goes through a registered IDLE/SETUP/ACCESS/RESP state machine with a wait-state timeout.

## Interface
- `ADDR_WIDTH`, default 32: APB address width; must match `mvu_pkg::APB_ADDR_WIDTH` at instantiation.
- `DATA_WIDTH`, default 32: APB data width; must match `mvu_pkg::APB_DATA_WIDTH` at instantiation.
- `TIMEOUT_CYCLES`, default 256: maximum ACCESS-phase cycles without `pready`. Value 0 disables the timeout.

Ports (clock and reset first):
- `clk` in 1: the only clock. All logic is rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when high together with `cmd_valid`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_WIDTH: target address.
- `cmd_wdata` in DATA_WIDTH: write data.
- `cmd_strb` in DATA_WIDTH/8: write byte strobes.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out DATA_WIDTH: read data; 0 for writes and for timeouts.
- `rsp_err` out 1: set by `pslverr` or by a timeout.
- `rsp_timeout` out 1: set by a timeout only.
- `paddr` out ADDR_WIDTH: APB address.
- `pprot` out 3: APB protection; constant 3'b000.
- `psel` out 1: APB select.
- `penable` out 1: APB enable.
- `pwrite` out 1: APB direction.
- `pwdata` out DATA_WIDTH: APB write data.
- `pstrb` out DATA_WIDTH/8: APB strobes; 0 on reads.
- `pready` in 1: slave ready.
- `prdata` in DATA_WIDTH: slave read data.
- `pslverr` in 1: slave error.

## Operation
- **IDLE:**
  - `cmd_ready` = 1; it is high in IDLE only.
  - On `cmd_valid`, latch write, addr, wdata and strb (strb forced to 0 for reads) into the APB output registers, clear the timeout counter, and go to SETUP.
- **SETUP:** `psel` = 1, `penable` = 0. Unconditionally go to ACCESS.
- **ACCESS:** `psel` = 1, `penable` = 1.
  - If `pready`: capture `rsp_rdata` (`prdata` for reads, 0 for writes), set `rsp_err` = `pslverr`, `rsp_timeout` = 0. Deassert `psel` and `penable`, go to RESP.
  - Else if TIMEOUT_CYCLES ≠ 0 and counter = TIMEOUT_CYCLES−1: abort. `rsp_rdata` = 0, `rsp_err` = 1, `rsp_timeout` = 1. Deassert `psel` and `penable`, go to RESP.
  - Otherwise increment the counter (width clog2(TIMEOUT_CYCLES+1), saturating).
- **RESP:** `rsp_valid` = 1.
  - Response fields are held stable until `rsp_ready`, then go to IDLE.
  - No new command is accepted while in RESP.
- `paddr`, `pwrite`, `pwdata` and `pstrb` are stable from SETUP through the last ACCESS cycle. Between transfers they hold their last values.
- `pready` and `pslverr` are ignored outside ACCESS.
- All outputs are registered, except `cmd_ready`, which is decoded from state.

## Timing
- Reset values:
  - State IDLE.
  - `psel`, `penable`, `pwrite`, `rsp_valid`, `rsp_err`, `rsp_timeout` = 0.
  - `paddr`, `pwdata`, `pstrb`, `rsp_rdata` = 0.
  - `cmd_ready` = 1 once reset deasserts.
- Latency, with the command accepted at edge 0:
  - SETUP is visible in cycle 1 and ACCESS in cycle 2.
  - With zero wait states, `pready` is sampled at edge 3, so `rsp_valid` is high in cycle 3.
  - With `rsp_ready` = 1 the block returns to IDLE in cycle 4.
  - Minimum period is 4 cycles per access. Each wait state adds 1 cycle.
- Timeout: after TIMEOUT_CYCLES ACCESS cycles with `pready` low, `rsp_valid` rises in the next cycle. If `pready` and the timeout fire on the same edge, `pready` wins.
- Reset mid-transfer: `psel`, `penable` and `rsp_valid` drop immediately (asynchronously). The in-flight command and response are discarded. There is no retry.
- `rsp_ready` may be held high permanently. `cmd_valid` may stay high across transfers; one command is taken per IDLE visit.

## Test plan
- **Write, zero wait:** cmd write, addr 0x10, wdata 0xDEADBEEF, strb 0xF; slave `pready` = 1.
  - Required: `psel` rises in cycle 1 and `penable` in cycle 2.
  - Required: `paddr` = 0x10, `pwrite` = 1, `pwdata` = 0xDEADBEEF throughout SETUP and ACCESS.
  - Required: `rsp_valid` in cycle 3 with `rsp_err` = 0 and `rsp_rdata` = 0.
- **Read, 3 wait states:** addr 0x24; `prdata` = 0x12345678 on the `pready` cycle.
  - Required: `rsp_rdata` = 0x12345678 and `pstrb` = 0.
  - Required: `rsp_valid` rises 6 cycles after acceptance.
- **Slave error:** `pslverr` = 1 with `pready` → `rsp_err` = 1, `rsp_timeout` = 0.
- **Timeout:** TIMEOUT_CYCLES = 4, `pready` held 0.
  - Required: `psel` drops after 4 ACCESS cycles.
  - Required: response with `rsp_err` = 1, `rsp_timeout` = 1, `rsp_rdata` = 0.
  - Required: the next command completes normally.
- **Backpressure:** `rsp_ready` = 0 for 10 cycles with `cmd_valid` held high.
  - Required: the response stays stable, `cmd_ready` = 0 and `psel` = 0.
  - Required: the second command is accepted the cycle after the `rsp_ready` handshake.
- **Reset mid-ACCESS:** assert `rst` while `pready` = 0 → `psel`, `penable` and `rsp_valid` fall in the same cycle; no response is issued after reset.
